bitfusion_pe: RTL and testbench

Parametrised, pipelined Bit-Fusion processing element: accepts a stream of packed input/weight words over a valid/ready handshake and multiplies them at a runtime-selected precision, with multiple narrow products fused per cycle. It accumulates the products over a vector delimited by `in_last` and presents the dot product on a held output handshake. It is the successor to the single-cycle registered fusion-unit top: it adds operand width generics, a runtime precision select, an accumulator, flow control and a drain/hold state machine. It is the tile building block for the systolic array.

---
 rtl/bitfusion_pe.sv | 193 +++++++++++++++++++
 tb/tb_bitfusion_pe.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitfusion_pe.sv
// Bit-Fusion PE: runtime-precision fused lane multiply, vector accumulate, held result handshake.
// Optional build macro BITFUSION_SAT_EN makes the accumulator saturate instead of wrap.

module bitfusion_lane #(
  parameter int IN_W = 8,
  parameter int WT_W = 8,
  parameter int PW   = 18,
  parameter int LANE = 0
) (
  input  logic [IN_W-1:0]       in,
  input  logic [WT_W-1:0]       weight,
  input  logic [2:0]            in_code,
  input  logic [2:0]            weight_code,
  input  logic                  s_in,
  input  logic                  s_weight,
  output logic signed [PW-1:0]  prod
);
  logic [IN_W-1:0] a_raw;
  logic [WT_W-1:0] b_raw;
  logic signed [PW-1:0] a, b;
  logic a_neg, b_neg;
  int ib, wb, lanes;

  always_comb begin
    ib = 1 << in_code;
    wb = 1 << weight_code;
    lanes = ((IN_W >> in_code) < (WT_W >> weight_code)) ? (IN_W >> in_code) : (WT_W >> weight_code);
    a_raw = (in >> (LANE * ib)) & ~({IN_W{1'b1}} << ib);
    b_raw = (weight >> (LANE * wb)) & ~({WT_W{1'b1}} << wb);
    // lane is already masked, so shifting by width-1 leaves just its top bit
    a_neg = s_in && (|(a_raw >> (ib - 1)));
    b_neg = s_weight && (|(b_raw >> (wb - 1)));
    a = PW'(a_raw);
    b = PW'(b_raw);
    if (a_neg) a = a | ({PW{1'b1}} << ib);
    if (b_neg) b = b | ({PW{1'b1}} << wb);
    prod = (LANE < lanes) ? a * b : '0;
  end
endmodule

module bitfusion_pe #(
  parameter int IN_W  = 8,
  parameter int WT_W  = 8,
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in,
  input  logic [WT_W-1:0]  weight,
  input  logic [2:0]       in_width,
  input  logic [2:0]       weight_width,
  input  logic             s_in,
  input  logic             s_weight,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [ACC_W-1:0] psum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             cfg_err
);
  localparam int PW = IN_W + WT_W + 2;
  localparam int NUM_LANES = ((IN_W < WT_W) ? IN_W : WT_W) / 2;
  localparam int SW = ((ACC_W > PW) ? ACC_W : PW) + 1;
  localparam int STAGES = 2;
  localparam logic [2:0] IN_LG = 3'($clog2(IN_W));
  localparam logic [2:0] WT_LG = 3'($clog2(WT_W));
  localparam logic signed [SW-1:0] AMAX = SW'({1'b0, {(ACC_W-1){1'b1}}});
  localparam logic signed [SW-1:0] AMIN = ~AMAX;

  typedef enum logic [1:0] {IDLE, ACC, DRAIN, HOLD} state_t;
  typedef struct packed {
    logic [2:0] ic;
    logic [2:0] wc;
    logic       si;
    logic       sw;
  } cfg_t;

  state_t state;
  cfg_t   cfg;
  logic accept, clr, in_bad, wt_bad;
  logic [STAGES:0] vld_pipe, last_pipe;
  logic [IN_W-1:0] s0_in;
  logic [WT_W-1:0] s0_wt;
  logic [NUM_LANES-1:0][PW-1:0] prod;
  logic signed [PW-1:0] fused, s1_sum;
  logic signed [SW-1:0] tot;
  logic signed [ACC_W-1:0] acc, acc_next;
  logic sat_hit, sat_now;

  assign accept = in_valid && in_ready;
  assign clr    = (state == HOLD) && out_ready;
  assign in_bad = (in_width == 3'd0) || (in_width > IN_LG);
  assign wt_bad = (weight_width == 3'd0) || (weight_width > WT_LG);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    bitfusion_lane #(.IN_W(IN_W), .WT_W(WT_W), .PW(PW), .LANE(g)) u_lane (
      .in(s0_in), .weight(s0_wt), .in_code(cfg.ic), .weight_code(cfg.wc),
      .s_in(cfg.si), .s_weight(cfg.sw), .prod(prod[g])
    );
  end

  always_comb begin
    fused = '0;
    for (int i = 0; i < NUM_LANES; i++) fused = fused + prod[i];
  end

  always_comb begin
    tot = SW'(acc) + SW'(s1_sum);
    acc_next = tot[ACC_W-1:0];
    sat_now = 1'b0;
`ifdef BITFUSION_SAT_EN
    if (tot > AMAX) begin
      acc_next = AMAX[ACC_W-1:0];
      sat_now = 1'b1;
    end else if (tot < AMIN) begin
      acc_next = AMIN[ACC_W-1:0];
      sat_now = 1'b1;
    end
`endif
  end

  // vld_pipe[0]=S0 operands, [1]=S1 fused sum, [2]=beat folded into acc
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
      s0_in     <= '0;
      s0_wt     <= '0;
      s1_sum    <= '0;
      acc       <= '0;
      sat_hit   <= 1'b0;
    end else begin
      vld_pipe  <= {vld_pipe[STAGES-1:0], accept};
      last_pipe <= {last_pipe[STAGES-1:0], accept && in_last};
      if (accept) begin
        s0_in <= in;
        s0_wt <= weight;
      end
      if (vld_pipe[0]) s1_sum <= fused;
      if (clr) begin
        acc     <= '0;
        sat_hit <= 1'b0;
      end else if (vld_pipe[1] && !sat_hit) begin
        acc     <= acc_next;
        sat_hit <= sat_now;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      psum      <= '0;
      cfg       <= '0;
      cfg_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            cfg <= '{ic: in_bad ? IN_LG : in_width, wc: wt_bad ? WT_LG : weight_width,
                     si: s_in, sw: s_weight};
            cfg_err <= cfg_err | in_bad | wt_bad;
            if (in_last) begin
              state    <= DRAIN;
              in_ready <= 1'b0;
            end else begin
              state <= ACC;
            end
          end
        end
        ACC: if (accept && in_last) begin
          state    <= DRAIN;
          in_ready <= 1'b0;
        end
        DRAIN: if (last_pipe[STAGES]) begin
          state     <= HOLD;
          out_valid <= 1'b1;
          psum      <= acc;
        end
        HOLD: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bitfusion_pe.sv
// Scoreboard bench for bitfusion_pe: randomized vectors against an arithmetic lane model.
module tb_bitfusion_pe;
  localparam int IN_W = 8, WT_W = 8, ACC_W = 16;
  localparam longint AMAX = (longint'(1) << (ACC_W - 1)) - 1;
  localparam longint AMIN = -(longint'(1) << (ACC_W - 1));

  logic clk = 1'b0, rst = 1'b1;
  logic [IN_W-1:0] in;
  logic [WT_W-1:0] weight;
  logic [2:0] in_width, weight_width;
  logic s_in, s_weight, in_valid, in_last, in_ready, out_valid, out_ready, cfg_err;
  logic [ACC_W-1:0] psum;

  bitfusion_pe #(.IN_W(IN_W), .WT_W(WT_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .in(in), .weight(weight), .in_width(in_width),
    .weight_width(weight_width), .s_in(s_in), .s_weight(s_weight), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .psum(psum), .out_valid(out_valid),
    .out_ready(out_ready), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  longint cyc = 0, last_t = 0;
  longint exp_q[$];
  bit exp_err = 0, or_rand = 0, ovr_en = 0;
  longint ovr_val = 0;
  longint m_acc = 0;
  bit m_sat = 0, m_first = 1, m_si = 0, m_sw = 0;
  int m_ic = 3, m_wc = 3;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint lane_val(input longint w, input int bits, input bit s);
    longint v = w & ((longint'(1) << bits) - 1);
    if (s && v >= (longint'(1) << (bits - 1))) v -= longint'(1) << bits;
    return v;
  endfunction

  function automatic int legal(input int c, input int lg);
    return (c < 1 || c > lg) ? lg : c;
  endfunction

  function automatic longint beat_prod(input longint a, input longint b, input int ic,
                                       input int wc, input bit si, input bit sw);
    int ib = 1 << ic, wb = 1 << wc;
    int nl = (IN_W / ib < WT_W / wb) ? IN_W / ib : WT_W / wb;
    longint p = 0;
    for (int i = 0; i < nl; i++)
      p += lane_val(a >> (i * ib), ib, si) * lane_val(b >> (i * wb), wb, sw);
    return p;
  endfunction

  function automatic longint wrap(input longint x);
    logic signed [ACC_W-1:0] t;
    t = x[ACC_W-1:0];
    return longint'(t);
  endfunction

  task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic [2:0] ic,
                      input logic [2:0] wc, input bit si, input bit sw, input bit last);
    int n = 0;
    longint p;
    in = a; weight = b; in_width = ic; weight_width = wc; s_in = si; s_weight = sw;
    in_last = last; in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout: in_ready stayed 0 for %0d cycles", n);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (m_first) begin
      m_ic = legal(ic, $clog2(IN_W)); m_wc = legal(wc, $clog2(WT_W));
      if (m_ic != ic || m_wc != wc) exp_err = 1;
      m_si = si; m_sw = sw; m_acc = 0; m_sat = 0; m_first = 0;
    end
    p = beat_prod(a, b, m_ic, m_wc, m_si, m_sw);
`ifdef BITFUSION_SAT_EN
    if (!m_sat) begin
      m_acc += p;
      if (m_acc > AMAX) begin m_acc = AMAX; m_sat = 1; end
      else if (m_acc < AMIN) begin m_acc = AMIN; m_sat = 1; end
    end
`else
    m_acc += p;
`endif
    if (last) begin
      exp_q.push_back(ovr_en ? ovr_val : wrap(m_acc));
      ovr_en = 0;
      last_t = cyc;
      m_first = 1;
      in_valid = 1'b0;
      in_last = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; in_last = 1'b0;
    in = 8'($urandom); weight = 8'($urandom);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(posedge clk); n++; end
    #1;
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d results outstanding", exp_q.size());
    end
  endtask

  // out_ready pacing
  initial begin
    forever begin
      @(posedge clk); #1;
      if (or_rand) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // monitor: pops scoreboard on each output handshake, checks hold and latency
  initial begin
    bit prev_ov = 0, prev_hs = 0;
    logic [ACC_W-1:0] prev_psum = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_ov = 0; prev_hs = 0;
      end else begin
        if (prev_hs) begin
          chk("ov_fall", out_valid, 0);
          chk("ready_return", in_ready, 1);
        end
        if (out_valid) begin
          chk("ready_in_hold", in_ready, 0);
          if (!prev_ov || prev_hs) chk("latency", cyc - last_t, 3);
          else chk("psum_stable", psum, prev_psum);
        end
        prev_hs = out_valid && out_ready;
        if (prev_hs) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_result: got %0d with empty scoreboard", $signed(psum));
          end else begin
            chk("psum", longint'($signed(psum)), exp_q.pop_front());
          end
          chk("cfg_err", cfg_err, exp_err);
        end
        prev_ov = out_valid;
        prev_psum = psum;
      end
    end
  end

  initial begin
    int n, n_ov;
    in = '0; weight = '0; in_width = 3'd3; weight_width = 3'd3; s_in = 0; s_weight = 0;
    in_valid = 0; in_last = 0; out_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_psum", psum, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_cfg_err", cfg_err, 0);
    rst = 0;
    #1 chk("ready_before_edge", in_ready, 0);
    @(posedge clk); #1;
    chk("ready_after_edge", in_ready, 1);
    or_rand = 1;

    // 8-bit signed, 3 beats
    beat(8'hFD, 8'h05, 3, 3, 1, 1, 0);
    beat(8'hFD, 8'h05, 3, 3, 1, 1, 0);
    ovr_en = 1; ovr_val = -45;
    beat(8'hFD, 8'h05, 3, 3, 1, 1, 1);
    drain();
    // 4-bit unsigned fusion
    ovr_en = 1; ovr_val = 11;
    beat(8'h21, 8'h43, 2, 2, 0, 0, 1);
    drain();
    // 2-bit signed fusion
    ovr_en = 1; ovr_val = -4;
    beat(8'hFF, 8'h55, 1, 1, 1, 1, 1);
    drain();

    // backpressure
    or_rand = 0; out_ready = 0;
    beat(8'h07, 8'h09, 3, 3, 1, 1, 1);
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 20);
    chk("bp_ov_seen", out_valid, 1);
    n_ov = 0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_ready_low", in_ready, 0);
      chk("bp_ov_high", out_valid, 1);
    end
    @(posedge clk); #1 out_ready = 1;
    @(posedge clk); #1 out_ready = 0;
    chk("bp_ov_after", out_valid, 0);
    chk("bp_ready_after", in_ready, 1);
    or_rand = 1;
    drain();

    // overflow with illegal width code 0 (treated as full width)
    beat(8'd127, 8'd127, 0, 0, 1, 1, 0);
    beat(8'd127, 8'd127, 0, 0, 1, 1, 0);
    ovr_en = 1;
`ifdef BITFUSION_SAT_EN
    ovr_val = 32767;
`else
    ovr_val = -17149;
`endif
    beat(8'd127, 8'd127, 0, 0, 1, 1, 1);
    drain();
    chk("cfg_err_set", cfg_err, 1);
    idle(3);
    chk("cfg_err_sticky", cfg_err, 1);

    // reset mid-vector
    beat(8'h11, 8'h22, 3, 3, 1, 1, 0);
    beat(8'h33, 8'h44, 3, 3, 1, 1, 0);
    in_valid = 0;
    rst = 1;
    #2;
    chk("mid_rst_psum", psum, 0);
    chk("mid_rst_ov", out_valid, 0);
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_cfg_err", cfg_err, 0);
    m_first = 1; exp_err = 0;
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1;
    ovr_en = 1; ovr_val = 6;
    beat(8'd2, 8'd3, 3, 3, 1, 1, 1);
    drain();
    chk("cfg_err_cleared", cfg_err, 0);

    // randomized vectors; cfg inputs wander mid-vector and must be ignored
    repeat (60) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        logic [2:0] ic, wc;
        ic = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 3));
        wc = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 3));
        beat(8'($urandom), 8'($urandom), ic, wc, 1'($urandom), 1'($urandom), i == n - 1);
        if (i != n - 1 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    drain();
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
